// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the DIV/DIVU sequencer: widths, FSM state encoding
// and handshake constants.
package div_ctrl_pkg;

  localparam int unsigned DivDataW     = 32;
  localparam int unsigned DivCntW      = 6;
  localparam int unsigned DoubleRegBus = 2 * DivDataW;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

endpackage : div_ctrl_pkg

// File: rtl/div_ctrl_if.sv
// EX-stage <-> divider handshake: operands and request in, {rem, quo} and ready out.
interface div_ctrl_if;
  import div_ctrl_pkg::*;

  logic                    signed_div_i;
  logic [DivDataW-1:0]     opdata1_i;
  logic [DivDataW-1:0]     opdata2_i;
  logic                    start_i;
  logic                    annul_i;
  logic [DoubleRegBus-1:0] result_o;
  logic                    ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface : div_ctrl_if

// File: rtl/div_ctrl.sv
// Radix-2 restoring divider sequencer for DIV/DIVU, one quotient bit per clock.
// The quotient is shifted into the dividend register as the dividend drains out.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DivDataW,
  parameter int unsigned CNT_W  = DivCntW
) (
  input logic       clk,
  input logic       rst,
  div_ctrl_if.slave div_if
);

  div_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   dvd_q;
  logic [DATA_W-1:0]   dsr_q;
  logic [DATA_W-1:0]   rem_q;
  logic                neg_quo_q;
  logic                neg_rem_q;
  logic [2*DATA_W-1:0] result_q;
  logic                ready_q;

  logic [DATA_W:0]     rem_sh;
  logic [DATA_W:0]     trial;
  logic [DATA_W-1:0]   rem_d;
  logic [DATA_W-1:0]   dvd_d;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;
  logic                sign1;
  logic                sign2;
  logic [DATA_W-1:0]   abs1;
  logic [DATA_W-1:0]   abs2;

  // One restoring step, final sign fix-up and operand magnitudes.
  always_comb begin
    rem_sh  = {rem_q, dvd_q[DATA_W-1]};
    trial   = rem_sh - {1'b0, dsr_q};
    rem_d   = trial[DATA_W] ? rem_sh[DATA_W-1:0] : trial[DATA_W-1:0];
    dvd_d   = {dvd_q[DATA_W-2:0], ~trial[DATA_W]};
    quo_fix = neg_quo_q ? -dvd_q : dvd_q;
    rem_fix = neg_rem_q ? -rem_q : rem_q;
    sign1   = div_if.signed_div_i & div_if.opdata1_i[DATA_W-1];
    sign2   = div_if.signed_div_i & div_if.opdata2_i[DATA_W-1];
    abs1    = sign1 ? -div_if.opdata1_i : div_if.opdata1_i;
    abs2    = sign2 ? -div_if.opdata2_i : div_if.opdata2_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      case (state_q)
        DivFree: begin
          result_q <= '0;
          ready_q  <= DivResultNotReady;
          if (div_if.start_i == DivStart && !div_if.annul_i) begin
            if (div_if.opdata2_i == '0) begin
              state_q <= DivByZero;
            end else begin
              state_q   <= DivOn;
              cnt_q     <= '0;
              dvd_q     <= abs1;
              dsr_q     <= abs2;
              rem_q     <= '0;
              neg_quo_q <= sign1 ^ sign2;
              neg_rem_q <= sign1;
            end
          end
        end
        DivByZero: begin
          state_q  <= DivEnd;
          result_q <= '0;
          ready_q  <= DivResultReady;
        end
        DivOn: begin
          // Flush wins over iteration so a squashed instruction never completes.
          if (div_if.annul_i) begin
            state_q  <= DivFree;
            result_q <= '0;
            ready_q  <= DivResultNotReady;
          end else if (cnt_q != CNT_W'(DATA_W)) begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            state_q  <= DivEnd;
            result_q <= {rem_fix, quo_fix};
            ready_q  <= DivResultReady;
          end
        end
        DivEnd: begin
          if (div_if.start_i == DivStop) begin
            state_q  <= DivFree;
            result_q <= '0;
            ready_q  <= DivResultNotReady;
          end
        end
        default: state_q <= DivFree;
      endcase
    end
  end

  assign div_if.result_o = result_q;
  assign div_if.ready_o  = ready_q;

endmodule : div_ctrl

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle sequencer for DIV/DIVU: radix-2 restoring division, one quotient bit per clock.
- Sits beside the EX stage. EX raises start_i, holds operands stable and stalls the pipeline until ready_o.
- Result feeds the HI/LO write path: HI = remainder, LO = quotient.
- Owns the handshake, the iteration counter, divide-by-zero and annul handling.

Parameters:
- DATA_W, 32, operand width; quotient and remainder are each DATA_W bits.
- CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset.
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  in  DATA_W  dividend; stable while start_i=1.
- opdata2_i  in  DATA_W  divisor; stable while start_i=1.
- start_i  in  1  request; held high by EX until ready_o seen.
- annul_i  in  1  abort current division (flush/exception).
- result_o  out  2*DATA_W  {remainder, quotient}.
- ready_o  out  1  result valid.

Behaviour:
- Reset: rst is synchronous, active-high. On reset: state=IDLE, cnt=0, result_o=0, ready_o=0, internal dividend/divisor registers=0. Reset mid-operation discards all progress.
- States: IDLE, BYZERO, ON, END.
- IDLE:
  - start_i=1 and annul_i=0 and opdata2_i=0 -> BYZERO.
  - start_i=1 and annul_i=0 and opdata2_i≠0 -> ON, cnt=0.
    - Latch |opdata1_i| and |opdata2_i|; magnitudes are taken only when signed_div_i=1 and the sign bit is set.
    - Latch sign flags: quotient negative = sign1 XOR sign2; remainder negative = sign1; both only when signed.
    - Partial remainder = 0.
  - Otherwise stay in IDLE; ready_o=0, result_o=0.
- BYZERO: next edge -> END; result_o = 0; ready_o=1.
- ON:
  - annul_i=1 -> IDLE, ready_o=0, result_o=0. annul_i takes priority over iteration.
  - cnt<DATA_W, one iteration per edge:
    - Shift {rem, dvd} left by 1.
    - trial = rem_shifted − divisor, computed DATA_W+1 wide.
    - trial non-negative -> rem = trial, quotient LSB = 1; else rem unchanged, quotient LSB = 0.
    - cnt++.
  - cnt==DATA_W:
    - Apply sign correction: two's-complement negate quotient and/or remainder per the latched flags.
    - Register result_o = {rem, quo}, ready_o=1 -> END.
- END:
  - Hold result_o and ready_o while start_i=1.
  - start_i=0 -> IDLE, ready_o=0, result_o=0 on that edge.
  - annul_i in END is ignored; EX drops start_i instead.
- Latency: the edge sampling start_i=1 in IDLE is E0.
  - Normal: iterations on E1..E32; E33 enters END; ready_o first observed high after E33 (34 edges total).
  - Divide-by-zero: ready_o high after E1.
- A new division needs a return to IDLE (start_i low for ≥1 edge). Back-to-back requests cost one idle cycle.
- annul_i in IDLE blocks a start on the same edge.
- Overflow: signed 0x80000000 / 0xFFFFFFFF wraps to quotient 0x80000000, remainder 0. No trap, no flag.
- Divide by zero is not flagged; architecturally result is UNPREDICTABLE, and we define it as 0.
- Outputs are registered; no combinational path from inputs to ready_o/result_o.

Decomposition:
- Shared defines package:
  - State encodings: DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11.
  - Handshake constants: DivStart/DivStop, DivResultReady/DivResultNotReady.
  - Widths: DoubleRegBus for result_o.
- No sub-module required. Optional combinational helper div_step (shift + trial subtract, DATA_W+1 bits) if it simplifies equivalence checking. The FSM stays in div_ctrl.

Test Plan:
1. DIVU 7/2, start held -> ready_o high after E33; result_o={0x00000001,0x00000003}; start_i low -> ready_o=0 next edge.
2. DIV 0xFFFFFFF9 (−7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7 / 0xFFFFFFFE -> quotient 0xFFFFFFFD, remainder 0x00000001.
3. Divisor 0 (any dividend, both signedness) -> ready_o after E1; result_o=0; start_i held 5 extra cycles -> outputs stable.
4. annul_i pulsed when cnt==10 -> IDLE, ready_o never rises. Then DIVU 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0, full 34-edge latency.
5. DIV 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0. DIVU same operands -> quotient 0, remainder 0x80000000.
6. rst asserted at cnt==20 -> all outputs 0 next edge. Then DIVU 100/7 with no idle gap after reset release -> {0x00000002,0x0000000E}.
